// File: rtl/sd_spi_responder_pkg.sv
// SD card SPI-mode responder: shared types and constants.
// Imported by the synchronizer and the responder top.
package sd_spi_responder_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_CMD,
        NCR,
        TX_RESP,
        NAC,
        TX_TOKEN,
        TX_DATA,
        TX_CRC
    } state_t;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [7:0] DATA_TOKEN = 8'hFE;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;

    function automatic logic [7:0] r1_byte(
        input logic illegal,
        input logic idle
    );
        logic [7:0] r;
        r = '0;
        r[R1_IDLE_BIT]    = idle;
        r[R1_ILLEGAL_BIT] = illegal;
        return r;
    endfunction

endpackage

// File: rtl/sd_spi_responder_sync.sv
// Two-flop synchronizers for the SPI pins plus
// rising/falling edge detect on the synchronized clock.
module sd_spi_responder_sync
    import sd_spi_responder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic spi_clk,
    input  logic sd_data_in,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic cs_meta;
    logic sck_meta;
    logic sck_s;
    logic sck_prev;
    logic mosi_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta   <= 1'b1;
            cs_n_s    <= 1'b1;
            sck_meta  <= 1'b0;
            sck_s     <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b1;
            mosi_s    <= 1'b1;
        end else begin
            cs_meta   <= cs_n;
            cs_n_s    <= cs_meta;
            sck_meta  <= spi_clk;
            sck_s     <= sck_meta;
            sck_prev  <= sck_s;
            mosi_meta <= sd_data_in;
            mosi_s    <= mosi_meta;
        end
    end

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

endmodule

// File: rtl/sd_spi_responder.sv
// SD card SPI-mode responder: command framing, R1/R3/R7
// responses and CMD17 single-block reads from a byte source.
module sd_spi_responder
    import sd_spi_responder_pkg::*;
#(
    parameter int          BLOCK_BYTES = 512,
    parameter logic [31:0] OCR_VALUE   = 32'h40FF8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        spi_clk,
    input  logic        sd_data_in,
    output logic        sd_data_out,
    output logic        mem_rd_en,
    output logic [31:0] mem_blk,
    output logic [9:0]  mem_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg
);

    localparam logic [9:0] LAST_BYTE = 10'(BLOCK_BYTES - 1);

    state_t      state;
    state_t      next_state;
    logic        cs_s;
    logic        mosi;
    logic        sck_rise;
    logic        sck_fall;
    logic [45:0] rx_sr;
    logic [5:0]  rx_cnt;
    logic [2:0]  bit_cnt;
    logic [9:0]  byte_cnt;
    logic [7:0]  tx_sr;
    logic [7:0]  data_buf;
    logic [7:0]  load_byte;
    logic [39:0] resp_sr;
    logic        resp_long;
    logic        rd_go;
    logic        idle;
    logic        acmd_pend;
    logic        out_q;
    logic        rd_pend;

    logic        frame_done;
    logic        frame_ok;
    logic        tx_active;
    logic        byte_done;
    logic [9:0]  resp_last;
    logic [5:0]  d_idx;
    logic [31:0] d_arg;
    logic        d_acmd41;
    logic        d_idle;
    logic        d_illegal;
    logic [7:0]  d_r1;
    logic        d_long;
    logic [39:0] d_resp;

    sd_spi_responder_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .cs_n       (cs_n),
        .spi_clk    (spi_clk),
        .sd_data_in (sd_data_in),
        .cs_n_s     (cs_s),
        .mosi_s     (mosi),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall)
    );

    // rx_sr holds frame bits 46..1; bit 0 is still on mosi
    assign frame_done = (state == RX_CMD) && sck_rise
                        && (rx_cnt == 6'd47);
    assign frame_ok   = rx_sr[45] & mosi;
    assign tx_active  = (state != RX_IDLE) && (state != RX_CMD);
    assign byte_done  = tx_active && sck_fall && (bit_cnt == 3'd7);
    assign resp_last  = resp_long ? 10'd4 : 10'd0;
    assign d_idx      = rx_sr[44:39];
    assign d_arg      = rx_sr[38:7];

    always_comb begin
        d_acmd41  = (d_idx == CMD41) && acmd_pend;
        d_idle    = idle;
        d_illegal = 1'b1;
        if (d_idx == CMD0) d_idle = 1'b1;
        else if (d_acmd41) d_idle = 1'b0;
        unique case (1'b1)
            (d_idx == CMD0),
            (d_idx == CMD8),
            (d_idx == CMD55),
            (d_idx == CMD58),
            d_acmd41:          d_illegal = 1'b0;
            (d_idx == CMD17):  d_illegal = d_idle;
            default:           d_illegal = 1'b1;
        endcase
        d_r1   = r1_byte(d_illegal, d_idle);
        d_long = (d_idx == CMD8) || (d_idx == CMD58);
        if (d_idx == CMD8) d_resp = {d_r1, d_arg};
        else if (d_idx == CMD58) d_resp = {d_r1, OCR_VALUE};
        else d_resp = {d_r1, 32'hFFFF_FFFF};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (cs_s) begin
            next_state = RX_IDLE;
        end else begin
            unique case (state)
                RX_IDLE:
                    if (sck_rise && !mosi) next_state = RX_CMD;
                RX_CMD:
                    if (frame_done)
                        next_state = frame_ok ? NCR : RX_IDLE;
                NCR:
                    if (byte_done) next_state = TX_RESP;
                TX_RESP:
                    if (byte_done && byte_cnt == resp_last)
                        next_state = rd_go ? NAC : RX_IDLE;
                NAC:
                    if (byte_done) next_state = TX_TOKEN;
                TX_TOKEN:
                    if (byte_done) next_state = TX_DATA;
                TX_DATA:
                    if (byte_done && byte_cnt == LAST_BYTE)
                        next_state = TX_CRC;
                TX_CRC:
                    if (byte_done && byte_cnt == 10'd1)
                        next_state = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        sd_data_out = cs_s ? 1'b1 : out_q;
        case (next_state)
            TX_RESP:  load_byte = resp_sr[39:32];
            TX_TOKEN: load_byte = DATA_TOKEN;
            TX_DATA:  load_byte = data_buf;
            default:  load_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd_en <= 1'b0;
            mem_blk   <= '0;
            mem_addr  <= '0;
            cmd_valid <= 1'b0;
            cmd_index <= '0;
            cmd_arg   <= '0;
            rx_sr     <= '0;
            rx_cnt    <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            tx_sr     <= 8'hFF;
            data_buf  <= '0;
            resp_sr   <= '1;
            resp_long <= 1'b0;
            rd_go     <= 1'b0;
            idle      <= 1'b1;
            acmd_pend <= 1'b0;
            out_q     <= 1'b1;
            rd_pend   <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            cmd_valid <= 1'b0;
            rd_pend   <= mem_rd_en;
            if (rd_pend) data_buf <= mem_rd_data;
            if (cs_s) begin
                rx_cnt   <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                tx_sr    <= 8'hFF;
                out_q    <= 1'b1;
            end else begin
                if (state == RX_IDLE && sck_rise && !mosi)
                    rx_cnt <= 6'd1;
                if (state == RX_CMD && sck_rise && !frame_done) begin
                    rx_cnt <= rx_cnt + 6'd1;
                    rx_sr  <= {rx_sr[44:0], mosi};
                end
                if (frame_done && frame_ok) begin
                    cmd_valid <= 1'b1;
                    cmd_index <= d_idx;
                    cmd_arg   <= d_arg;
                    idle      <= d_idle;
                    acmd_pend <= (d_idx == CMD55);
                    rd_go     <= (d_idx == CMD17) && !d_illegal;
                    resp_sr   <= d_resp;
                    resp_long <= d_long;
                    tx_sr     <= 8'hFF;
                    bit_cnt   <= '0;
                    byte_cnt  <= '0;
                    if (d_idx == CMD17) mem_blk <= d_arg;
                end
                if (sck_fall) begin
                    if (tx_active) begin
                        out_q   <= tx_sr[7];
                        tx_sr   <= {tx_sr[6:0], 1'b1};
                        bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        out_q <= 1'b1;
                    end
                end
                if (byte_done) begin
                    tx_sr    <= load_byte;
                    byte_cnt <= (next_state == state)
                                ? byte_cnt + 10'd1 : 10'd0;
                    if (next_state == TX_RESP)
                        resp_sr <= {resp_sr[31:0], 8'hFF};
                    if (next_state == TX_TOKEN) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end
                    // byte mem_addr is loading now; prefetch the next
                    if (next_state == TX_DATA
                        && mem_addr != LAST_BYTE) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= mem_addr + 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter BLOCK_BYTES, default 512: bytes per CMD17 data block; power of two, 16..1024.
REQ-002 Parameter OCR_VALUE, default 32'h40FF8000: OCR returned by CMD58.
REQ-003 clk  input  1  single system clock; all logic on rising edge; clk frequency >= 6x spi_clk frequency.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs_n  input  1  host chip select, active low; asynchronous to clk.
REQ-006 spi_clk  input  1  host SPI clock, mode 0; asynchronous to clk.
REQ-007 sd_data_in  input  1  host-to-card serial data (MOSI).
REQ-008 sd_data_out  output  1  card-to-host serial data (MISO); idle 1.
REQ-009 mem_rd_en  output  1  one-clk read strobe to block source.
REQ-010 mem_blk  output  32  block address, i.e. CMD17 argument.
REQ-011 mem_addr  output  10  byte offset within block.
REQ-012 mem_rd_data  input  8  block byte, valid exactly 1 clk after mem_rd_en.
REQ-013 cmd_valid  output  1  one-clk pulse per accepted command frame.
REQ-014 cmd_index  output  6  and cmd_arg  output  32: last accepted command, held until the next one.

Function
REQ-015 cs_n, spi_clk and sd_data_in SHALL each pass a 2-flop synchronizer; spi_clk edges are detected on the synchronized signal.
REQ-016 MOSI SHALL be sampled on the detected rising edge of spi_clk; sd_data_out SHALL change only on the detected falling edge, MSB first.
REQ-017 Synchronized cs_n high SHALL force state RX_IDLE, sd_data_out=1 and clear the bit counters, at any point in a transaction.
REQ-018 States: RX_IDLE, RX_CMD, NCR, TX_RESP, NAC, TX_TOKEN, TX_DATA, TX_CRC.
REQ-019 RX_IDLE: the first sampled 0 bit moves to RX_CMD and is counted as frame bit 47.
REQ-020 RX_CMD: collect 48 bits; accept the frame only if bit46=1 and bit0=1, otherwise return to RX_IDLE with no response; CRC is not checked.
REQ-021 On accept: pulse cmd_valid, latch cmd_index=bits[45:40] and cmd_arg=bits[39:8], go to NCR.
REQ-022 NCR: transmit exactly one 0xFF byte, then TX_RESP.
REQ-023 Flag idle: set at reset and by CMD0; cleared by CMD41 only when the immediately preceding accepted command was CMD55 (ACMD41).
REQ-024 R1 = {5'b0, illegal, 1'b0, idle}; idle is the value after the current command takes effect.
REQ-025 Responses: CMD0 R1; CMD8 R1 + cmd_arg[31:0]; CMD55 R1; ACMD41 R1; CMD58 R1 + OCR_VALUE; CMD17 R1; any other index, or CMD17 while idle, R1 with illegal=1.
REQ-026 After the response: CMD17 with R1=0x00 goes to NAC, all others to RX_IDLE.
REQ-027 NAC sends one 0xFF; TX_TOKEN sends 0xFE; TX_DATA sends BLOCK_BYTES bytes, offsets 0..BLOCK_BYTES-1; TX_CRC sends 0xFF,0xFF, then RX_IDLE.
REQ-028 Prefetch: mem_rd_en pulses with mem_addr=0 on entering TX_TOKEN; with mem_addr=k+1 when byte k loads into the shift register; no strobe past the last byte.
REQ-029 Host MOSI content during transmit states is ignored; a new command is decoded only from RX_IDLE.
REQ-030 mem_addr SHALL not wrap; it stays at BLOCK_BYTES-1 after the last fetch.

Reset
REQ-031 On reset: state RX_IDLE, sd_data_out=1, mem_rd_en=0, mem_addr=0, mem_blk=0, cmd_valid=0, cmd_index=0, cmd_arg=0, idle=1, ACMD pending=0, synchronizers=1 for cs_n, 0 for spi_clk.

Structure
REQ-032 A shared package SHALL hold the state enum, command index constants (0,8,17,41,55,58), the token 0xFE and the R1 bit positions.
REQ-033 One sub-module, sd_spi_responder_sync (2-flop synchronizer plus edge detect), is natural; the FSM and shifters stay in the top.

Verification
REQ-034 CMD0 arg 0 CRC 0x95 -> cmd_valid, one 0xFF, R1=0x01, MISO returns high.
REQ-035 CMD8 arg 0x000001AA -> 0xFF, then 01 00 00 01 AA.
REQ-036 CMD55 then CMD41 -> R1 0x01 then 0x00; CMD41 without CMD55 -> 0x05.
REQ-037 After init, CMD17 arg 0x00000003, source returns mem_addr[7:0] -> mem_blk=3, 00, FF, FE, bytes 00..FF,00..FF, FF, FF; exactly 512 mem_rd_en.
REQ-038 cs_n raised after 100 data bytes -> MISO=1 in <=3 clk, state RX_IDLE, next CMD58 -> 00 40 FF 80 00.
REQ-039 Frame with bit46=0 -> no cmd_valid, MISO stays high.
